// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and reader state type for the register file slice
package regfile_pkg;

    localparam int ADDR_W = 5;
    localparam int WIDTH  = 32;
    localparam int NREGS  = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_SEND   = 2'd2,
        ST_FINISH = 2'd3
    } reader_state_t;

endpackage

// File: rtl/stream_out_reg.sv
// rtl/stream_out_reg.sv - held output word register (load / hold / clear)
module stream_out_reg
    import regfile_pkg::*;
#(
    parameter int W_DATA = WIDTH,
    parameter int W_ADDR = ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [W_ADDR-1:0] load_regnum,
    input  logic [W_DATA-1:0] load_data,
    output logic              valid,
    output logic [W_ADDR-1:0] regnum,
    output logic [W_DATA-1:0] data
);

    // Clearing drops only valid; regnum/data keep their last value.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid  <= 1'b0;
            regnum <= '0;
            data   <= '0;
        end else if (load) begin
            valid  <= 1'b1;
            regnum <= load_regnum;
            data   <= load_data;
        end else if (clear) begin
            valid  <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_stream_reader.sv
// rtl/regfile_stream_reader.sv - sweeps a register range and streams (regnum, value) words
module regfile_stream_reader
    import regfile_pkg::*;
#(
    parameter int W_DATA = WIDTH,
    parameter int W_ADDR = ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [W_ADDR-1:0] first_reg,
    input  logic [W_ADDR-1:0] last_reg,
    output logic [W_ADDR-1:0] rd_regnum,
    input  logic [W_DATA-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W_ADDR-1:0] out_regnum,
    output logic [W_DATA-1:0] out_data,
    output logic              busy,
    output logic              done
);

    reader_state_t     state;
    logic [W_ADDR-1:0] cur;
    logic [W_ADDR-1:0] last;
    logic              load;
    logic              handshake;

    // The read port address is the sweep pointer itself, so it is stable through FETCH.
    assign rd_regnum = cur;
    assign load      = (state == ST_FETCH);
    assign handshake = (state == ST_SEND) && out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cur   <= '0;
            last  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        cur   <= first_reg;
                        last  <= last_reg;
                        busy  <= 1'b1;
                        state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state <= ST_SEND;
                end
                ST_SEND: begin
                    if (handshake) begin
                        if (cur == last) begin
                            done  <= 1'b1;
                            state <= ST_FINISH;
                        end else begin
                            cur   <= cur + 1'b1;
                            state <= ST_FETCH;
                        end
                    end
                end
                ST_FINISH: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    stream_out_reg #(
        .W_DATA(W_DATA),
        .W_ADDR(W_ADDR)
    ) u_out (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .clear      (handshake),
        .load_regnum(cur),
        .load_data  (rd_data),
        .valid      (out_valid),
        .regnum     (out_regnum),
        .data       (out_data)
    );

endmodule

// File: tb/tb_regfile_stream_reader.sv
// tb/tb_regfile_stream_reader.sv - self-checking bench for regfile_stream_reader
module tb_regfile_stream_reader;
    import regfile_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] first_reg;
    logic [ADDR_W-1:0] last_reg;
    logic [ADDR_W-1:0] rd_regnum;
    logic [WIDTH-1:0]  rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_regnum;
    logic [WIDTH-1:0]  out_data;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;
    int got_reg[$];
    int got_dat[$];
    int exp_reg[$];
    int exp_dat[$];
    int done_cnt;
    int first_valid_cyc;
    int last_hs_cyc;
    int done_cyc;
    bit timed_out;

    always #5 clk = ~clk;

    // Register file model: reg[i] = i*11, combinational read.
    assign rd_data = WIDTH'(rd_regnum) * 32'd11;

    regfile_stream_reader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .first_reg (first_reg),
        .last_reg  (last_reg),
        .rd_regnum (rd_regnum),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_regnum(out_regnum),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    task automatic build_expected(input int f, input int l);
        int n;
        exp_reg.delete();
        exp_dat.delete();
        n = ((l - f + NREGS) % NREGS) + 1;
        for (int k = 0; k < n; k++) begin
            exp_reg.push_back((f + k) % NREGS);
            exp_dat.push_back(((f + k) % NREGS) * 11);
        end
    endtask

    task automatic do_start(input int f, input int l);
        first_reg = ADDR_W'(f);
        last_reg  = ADDR_W'(l);
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic collect(input int ready_pct, input int max_hs);
        int cyc;
        bit r;
        got_reg.delete();
        got_dat.delete();
        done_cnt = 0;
        first_valid_cyc = -1;
        last_hs_cyc = -1;
        done_cyc = -1;
        timed_out = 1'b0;
        cyc = 1;
        forever begin
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (!busy) break;
            if (cyc > 3000) begin
                timed_out = 1'b1;
                break;
            end
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            r = ($urandom_range(99) < ready_pct);
            out_ready = r;
            if (out_valid && r) begin
                got_reg.push_back(int'(out_regnum));
                got_dat.push_back(int'(out_data));
                last_hs_cyc = cyc;
            end
            @(posedge clk); #1;
            cyc++;
            if (max_hs > 0 && got_reg.size() >= max_hs) break;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
        checks++; if (rd_regnum !== '0) begin errors++; $display("FAIL reset_rd_regnum got %0d want 0", rd_regnum); end
        checks++; if (out_regnum !== '0) begin errors++; $display("FAIL reset_out_regnum got %0d want 0", out_regnum); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %0d want 0", out_data); end
    endtask

    task automatic test_basic();
        build_expected(2, 4);
        do_start(2, 4);
        collect(100, 0);
        checks++; if (timed_out) begin errors++; $display("FAIL basic_timeout got 1 want 0"); end
        checks++; if (first_valid_cyc != 2) begin errors++; $display("FAIL basic_latency got %0d want 2", first_valid_cyc); end
        checks++; if (last_hs_cyc != 6) begin errors++; $display("FAIL basic_last_hs_cycle got %0d want 6", last_hs_cyc); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_count got %0d want 1", done_cnt); end
        checks++; if (done_cyc != last_hs_cyc + 1) begin errors++; $display("FAIL basic_done_cycle got %0d want %0d", done_cyc, last_hs_cyc + 1); end
        checks++; if (got_reg.size() != exp_reg.size()) begin errors++; $display("FAIL basic_word_count got %0d want %0d", got_reg.size(), exp_reg.size()); end
        for (int k = 0; k < got_reg.size() && k < exp_reg.size(); k++) begin
            checks++;
            if (got_reg[k] != exp_reg[k] || got_dat[k] != exp_dat[k])
                begin errors++; $display("FAIL basic_word%0d got (%0d,%0d) want (%0d,%0d)", k, got_reg[k], got_dat[k], exp_reg[k], exp_dat[k]); end
        end
    endtask

    task automatic test_stall();
        build_expected(2, 4);
        out_ready = 1'b0;
        do_start(2, 4);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid%0d got %0b want 1", i, out_valid); end
            checks++; if (out_data !== 32'd22) begin errors++; $display("FAIL stall_data%0d got %0d want 22", i, out_data); end
            checks++; if (out_regnum !== 5'd2 || rd_regnum !== 5'd2) begin errors++; $display("FAIL stall_regnum%0d got %0d/%0d want 2/2", i, out_regnum, rd_regnum); end
            @(posedge clk); #1;
        end
        collect(100, 0);
        checks++; if (got_reg.size() != 3 || done_cnt != 1) begin errors++; $display("FAIL stall_count got %0d words %0d done want 3 words 1 done", got_reg.size(), done_cnt); end
        for (int k = 0; k < got_reg.size() && k < exp_reg.size(); k++) begin
            checks++;
            if (got_reg[k] != exp_reg[k] || got_dat[k] != exp_dat[k])
                begin errors++; $display("FAIL stall_word%0d got (%0d,%0d) want (%0d,%0d)", k, got_reg[k], got_dat[k], exp_reg[k], exp_dat[k]); end
        end
    endtask

    task automatic test_wrap();
        build_expected(30, 1);
        do_start(30, 1);
        collect(70, 0);
        checks++; if (got_reg.size() != 4 || done_cnt != 1 || timed_out) begin errors++; $display("FAIL wrap_count got %0d words %0d done want 4 words 1 done", got_reg.size(), done_cnt); end
        for (int k = 0; k < got_reg.size() && k < exp_reg.size(); k++) begin
            checks++;
            if (got_reg[k] != exp_reg[k] || got_dat[k] != exp_dat[k])
                begin errors++; $display("FAIL wrap_word%0d got (%0d,%0d) want (%0d,%0d)", k, got_reg[k], got_dat[k], exp_reg[k], exp_dat[k]); end
        end
    endtask

    task automatic test_single_ignore_start();
        do_start(7, 7);
        first_reg = 5'd0;
        last_reg  = 5'd3;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        collect(100, 0);
        checks++; if (got_reg.size() != 1) begin errors++; $display("FAIL single_count got %0d want 1", got_reg.size()); end
        checks++; if (got_reg.size() > 0 && (got_reg[0] != 7 || got_dat[0] != 77)) begin errors++; $display("FAIL single_word got (%0d,%0d) want (7,77)", got_reg[0], got_dat[0]); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL single_done got %0d want 1", done_cnt); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL single_idle got busy %0b valid %0b want 0 0", busy, out_valid); end
    endtask

    task automatic test_reset_mid();
        do_start(0, 31);
        collect(100, 2);
        checks++; if (got_reg.size() != 2 || got_reg[0] != 0 || got_reg[1] != 1 || got_dat[1] != 11) begin errors++; $display("FAIL midreset_prefix got %0d words want (0,0),(1,11)", got_reg.size()); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got %0b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_done got %0b want 0", done); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midreset_quiet%0d got done %0b busy %0b want 0 0", i, done, busy); end
        end
        do_start(5, 5);
        collect(100, 0);
        checks++; if (got_reg.size() != 1 || got_reg[0] != 5 || got_dat[0] != 55 || done_cnt != 1) begin errors++; $display("FAIL midreset_resweep got %0d words done %0d want (5,55) done 1", got_reg.size(), done_cnt); end
    endtask

    task automatic test_random();
        int f, l, pct;
        for (int it = 0; it < 7; it++) begin
            f   = $urandom_range(NREGS - 1);
            l   = (it == 0) ? (f + NREGS - 1) % NREGS : int'($urandom_range(NREGS - 1));
            pct = $urandom_range(100, 30);
            build_expected(f, l);
            do_start(f, l);
            collect(pct, 0);
            checks++; if (timed_out || done_cnt != 1) begin errors++; $display("FAIL rand%0d_done got %0d timeout %0b want 1 0", it, done_cnt, timed_out); end
            checks++; if (got_reg.size() != exp_reg.size()) begin errors++; $display("FAIL rand%0d_count got %0d want %0d", it, got_reg.size(), exp_reg.size()); end
            for (int k = 0; k < got_reg.size() && k < exp_reg.size(); k++) begin
                checks++;
                if (got_reg[k] != exp_reg[k] || got_dat[k] != exp_dat[k])
                    begin errors++; $display("FAIL rand%0d_word%0d got (%0d,%0d) want (%0d,%0d)", it, k, got_reg[k], got_dat[k], exp_reg[k], exp_dat[k]); end
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        first_reg = '0;
        last_reg  = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        test_basic();
        test_stall();
        test_wrap();
        test_single_ignore_start();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
